seq_sum_processor: RTL

- Parametrised control-unit/datapath block that computes the arithmetic-series sum 0 + S + 2S + … up to a runtime limit L.
- Successor to the fixed 0..10 adder processor: adds configurable data width and sum width, a runtime limit and step, a start/done handshake, and overflow reporting.
- Sits between the top-level controller and the FND display driver. `out` feeds the display and is updated with every partial sum.

---
 rtl/seq_sum_if.sv | 18 +
 rtl/seq_sum_processor.sv | 103 ++++++++++
 2 files changed

// File: rtl/seq_sum_if.sv
// Start/done handshake and result bus for seq_sum_processor.
// Protocol: start is level-sampled only while busy=0; limit/step are taken on that same edge; done pulses for one cycle once sum/out/overflow are final.
interface seq_sum_if #(
    parameter int DATA_W = 8,
    parameter int SUM_W  = 16
);
    logic              start;
    logic [DATA_W-1:0] limit;
    logic [DATA_W-1:0] step;
    logic              busy;
    logic              done;
    logic [SUM_W-1:0]  sum;
    logic [DATA_W-1:0] out;
    logic              overflow;

    modport master (output start, limit, step, input busy, done, sum, out, overflow);
    modport slave  (input start, limit, step, output busy, done, sum, out, overflow);
endinterface

// File: rtl/seq_sum_processor.sv
// Arithmetic-series accumulator 0 + S + 2S + ... <= L with start/done handshake.
// Optional SEQ_SUM_SATURATE_EN clamps the accumulator instead of wrapping it.
module seq_sum_processor #(
    parameter int DATA_W = 8,
    parameter int SUM_W  = 16
) (
    input  logic       clk,
    input  logic       reset,
    seq_sum_if.slave   io_bus,
    output logic [2:0] o_state
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_CHECK = 3'd2,
        S_ADD   = 3'd3,
        S_INC   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [DATA_W:0]   r_i;
    logic [DATA_W-1:0] r_lim;
    logic [DATA_W-1:0] r_stp;
    logic [SUM_W-1:0]  r_sum;
    logic [DATA_W-1:0] r_out;
    logic              r_ovf;
    logic              r_busy;
    logic              r_done;
    logic [SUM_W:0]    w_add;
    logic              w_carry;
    logic [SUM_W-1:0]  w_sum_new;

    // One extra bit of headroom on the index lets the CHECK exit after L=2^DATA_W-1.
    assign w_add   = {1'b0, r_sum} + (SUM_W+1)'(r_i);
    assign w_carry = w_add[SUM_W];
`ifdef SEQ_SUM_SATURATE_EN
    assign w_sum_new = w_carry ? {SUM_W{1'b1}} : w_add[SUM_W-1:0];
`else
    assign w_sum_new = w_add[SUM_W-1:0];
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (io_bus.start) w_next = S_INIT;
            S_INIT:  w_next = S_CHECK;
            S_CHECK: w_next = (r_i <= {1'b0, r_lim}) ? S_ADD : S_DONE;
            S_ADD:   w_next = S_INC;
            S_INC:   w_next = S_CHECK;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_i     <= '0;
            r_lim   <= '0;
            r_stp   <= '0;
            r_sum   <= '0;
            r_out   <= '0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            // Status flags follow the state being entered so they stay registered.
            r_busy  <= (w_next != S_IDLE);
            r_done  <= (w_next == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (io_bus.start) begin
                        r_lim <= io_bus.limit;
                        r_stp <= (io_bus.step == '0) ? DATA_W'(1) : io_bus.step;
                    end
                end
                S_INIT: begin
                    r_i   <= '0;
                    r_sum <= '0;
                    r_out <= '0;
                    r_ovf <= 1'b0;
                end
                S_ADD: begin
                    r_sum <= w_sum_new;
                    r_out <= w_sum_new[DATA_W-1:0];
                    if (w_carry) r_ovf <= 1'b1;
                end
                S_INC:   r_i <= r_i + {1'b0, r_stp};
                default: ;
            endcase
        end
    end

    assign io_bus.busy     = r_busy;
    assign io_bus.done     = r_done;
    assign io_bus.sum      = r_sum;
    assign io_bus.out      = r_out;
    assign io_bus.overflow = r_ovf;
    assign o_state         = r_state;
endmodule
